// File: rtl/seq_div.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (truncating division).
module seq_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);
    // Handshake: start is sampled only while idle; busy covers the whole operation,
    // done is a one-cycle pulse and the result outputs change only together with it.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // The partial remainder's top bit is always zero after a restore or a
    // successful subtract, so only the low WIDTH bits are kept.
    logic [WIDTH-1:0] p, p_nxt;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] q, q_nxt, dvsr;
    logic [WIDTH-1:0] in_a, in_b, res_q, res_r;
    logic [CW-1:0]    cnt;

`ifdef SEQ_DIV_SIGNED_EN
    logic neg_q, neg_r;

    assign in_a  = dividend[WIDTH-1] ? (~dividend + ONE) : dividend;
    assign in_b  = divisor[WIDTH-1]  ? (~divisor + ONE)  : divisor;
    assign res_q = neg_q ? (~q_nxt + ONE) : q_nxt;
    assign res_r = neg_r ? (~p_nxt + ONE) : p_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && start) begin
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
        end
    end
`else
    assign in_a  = dividend;
    assign in_b  = divisor;
    assign res_q = q_nxt;
    assign res_r = p_nxt;
`endif

    // One restoring step: trial subtract, keep the shifted value on borrow.
    always_comb begin
        shifted = {p, q[WIDTH-1]};
        trial   = shifted - {1'b0, dvsr};
        p_nxt   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        q_nxt   = {q[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (divisor == '0) ? FIN : CALC;
            CALC: if (cnt == CNT_ONE) state_nxt = FIN;
            FIN:  if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p           <= '0;
            q           <= '0;
            dvsr        <= '0;
            cnt         <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    dvsr <= in_b;
                    p    <= '0;
                    // On divide-by-zero q parks the raw dividend for the remainder.
                    q    <= (divisor == '0) ? dividend : in_a;
                    cnt  <= (divisor == '0) ? '0 : CNT_INIT;
                end
                CALC: begin
                    p   <= p_nxt;
                    q   <= q_nxt;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        quotient    <= res_q;
                        remainder   <= res_r;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                FIN: begin
                    if (done) begin
                        done <= 1'b0;
                    end else begin
                        // Divide-by-zero arrives here without done; publish it one edge later.
                        quotient    <= '1;
                        remainder   <= q;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_seq_div.sv
// Scoreboard bench for seq_div: driver pushes model results, monitor pops on done.
// Also checks latency, single-cycle done, result hold, and async reset abort.
module tb_seq_div;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  logic [1:0] dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [2*W:0] exp_q[$];
  int lat_q[$];
  int start_q[$];
  logic [2*W:0] e_now;
  int s_now, l_now;
  logic [W-1:0] last_q = '0, last_r = '0;
  logic last_z = 1'b0;
  logic prev_done = 1'b0;

  seq_div #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: plain arithmetic on the operand values.
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] mq, mr;
`ifdef SEQ_DIV_SIGNED_EN
    int sa, sb;
`endif
    if (b == '0) return {1'b1, {W{1'b1}}, a};
`ifdef SEQ_DIV_SIGNED_EN
    sa = $signed(a);
    sb = $signed(b);
    if (sa == -(2 ** (W - 1)) && sb == -1) begin
      mq = a;
      mr = '0;
    end else begin
      mq = W'(sa / sb);
      mr = W'(sa % sb);
    end
`else
    mq = a / b;
    mr = a % b;
`endif
    return {1'b0, mq, mr};
  endfunction

  // driver tasks
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(negedge clk);
    exp_q.push_back(model(a, b));
    lat_q.push_back((b == '0) ? 1 : W);
    start_q.push_back(cyc);
    check("busy_after_start", busy, 1'b1);
    start = 1'b0;
    dividend = W'($urandom);
    divisor = W'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within 40 cycles");
    end
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b);
    issue(a, b);
    wait_done();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      last_q = '0;
      last_r = '0;
      last_z = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        check("done_single_cycle", prev_done, 1'b0);
        check("busy_with_done", busy, 1'b1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: q=%0h r=%0h", quotient, remainder);
        end else begin
          e_now = exp_q.pop_front();
          l_now = lat_q.pop_front();
          s_now = start_q.pop_front();
          check("quotient", quotient, e_now[2*W-1:W]);
          check("remainder", remainder, e_now[W-1:0]);
          check("div_by_zero", div_by_zero, e_now[2*W]);
          check("latency", cyc - s_now, l_now);
          last_q = e_now[2*W-1:W];
          last_r = e_now[W-1:0];
          last_z = e_now[2*W];
        end
      end else begin
        check("hold_quotient", quotient, last_q);
        check("hold_remainder", remainder, last_r);
        check("hold_div_by_zero", div_by_zero, last_z);
      end
      prev_done = done;
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);
    check("reset_dbz", div_by_zero, 1'b0);
    check("reset_state", dbg_state, 2'd0);
    rst_n = 1'b1;

    run(8'd100, 8'd7);
    run(8'd255, 8'd1);
    run(8'd5, 8'd9);
    repeat (5) @(negedge clk);
    run(8'd37, 8'd0);
    run(8'd20, 8'd4);

    // start pulsed mid-operation must be ignored
    issue(8'd200, 8'd3);
    repeat (2) @(negedge clk);
    start = 1'b1;
    dividend = 8'd10;
    divisor = 8'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);

    // asynchronous reset in the middle of an operation
    issue(8'd90, 8'd9);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_dbz", div_by_zero, 1'b0);
    exp_q.delete();
    lat_q.delete();
    start_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(8'd90, 8'd9);

`ifdef SEQ_DIV_SIGNED_EN
    run(8'h9C, 8'd7);
    run(8'd100, 8'hF9);
    run(8'h80, 8'hFF);
    run(8'h80, 8'h01);
    run(8'hF6, 8'h00);
`endif

    for (int i = 0; i < 1500; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = (i % 8 == 0) ? W'($urandom_range(1, 4)) : W'($urandom_range(1, 255));
      run(a, b);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    for (int i = 0; i < 20; i++) run(W'($urandom), '0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending_results: %0d expected results never seen", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
